// File: rtl/dmem_responder.sv
// Single-port data memory responder with RV32I load/store sizing, fixed wait
// states and a valid/ready request/response handshake.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  // state | meaning
  // IDLE  | ready for a request
  // WAIT  | legal request latched, counting down wait states
  // RESP  | response presented until rsp_ready
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_U = DEPTH_WORDS;
  localparam logic [3:0]  WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;
  logic            err_q;

  logic [31:0]     mem [DEPTH_WORDS];

  logic            in_idle, accept, req_err;
  logic            enter_resp, cur_err;
  logic            cur_we;
  logic [2:0]      cur_f3;
  logic [AW+1:0]   cur_addr;
  logic [31:0]     cur_wdata;
  logic [AW-1:0]   cur_widx;
  logic [31:0]     rd_word, load_val, st_data, merged;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [3:0]      st_be;

  assign in_idle = (state_q == IDLE);
  assign accept  = in_idle && req_valid;

  always_comb begin
    req_err = 1'b0;
    if (req_funct3[1:0] == 2'b01 && req_addr[0])
      req_err = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
      req_err = 1'b1;
    if (req_we && req_funct3 > 3'b010)
      req_err = 1'b1;
    if (!req_we && (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11))
      req_err = 1'b1;
    if ({2'b00, req_addr[31:2]} >= DEPTH_U)
      req_err = 1'b1;
  end

  // With zero wait states the access completes on the accept edge, so the
  // datapath works from the live request while idle and from the latch otherwise.
  assign cur_we    = in_idle ? req_we             : we_q;
  assign cur_f3    = in_idle ? req_funct3         : f3_q;
  assign cur_addr  = in_idle ? req_addr[AW+1:0]   : addr_q;
  assign cur_wdata = in_idle ? req_wdata          : wdata_q;
  assign cur_widx  = cur_addr[AW+1:2];

  assign rd_word = mem[cur_widx];
  assign byte_v  = rd_word[{cur_addr[1:0], 3'b000} +: 8];
  assign half_v  = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_val = 32'h0;
    case (cur_f3)
      3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_val = {{16{half_v[15]}}, half_v};
      3'b010:  load_val = rd_word;
      3'b100:  load_val = {24'h0, byte_v};
      3'b101:  load_val = {16'h0, half_v};
      default: load_val = 32'h0;
    endcase
  end

  always_comb begin
    st_be   = 4'b1111;
    st_data = cur_wdata;
    case (cur_f3[1:0])
      2'b00: begin
        st_be   = 4'b0001 << cur_addr[1:0];
        st_data = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        st_be   = cur_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{cur_wdata[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = cur_wdata;
      end
    endcase
    merged = rd_word;
    for (int i = 0; i < 4; i++)
      if (st_be[i])
        merged[8*i +: 8] = st_data[8*i +: 8];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    cur_err    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_err) begin
            state_d    = RESP;
            enter_resp = 1'b1;
            cur_err    = 1'b1;
          end else if (WAIT_STATES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WS_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr[AW+1:0];
        wdata_q <= req_wdata;
      end
      if (enter_resp) begin
        err_q   <= cur_err;
        rdata_q <= (cur_err || cur_we) ? 32'h0 : load_val;
      end else if (state_q == RESP && rsp_ready) begin
        err_q   <= 1'b0;
        rdata_q <= 32'h0;
      end
    end
  end

  // Storage is deliberately never reset.
  always_ff @(posedge clk) begin
    if (enter_resp && cur_we && !cur_err)
      mem[cur_widx] <= merged;
  end

  assign req_ready = in_idle;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed loads/stores, error cases,
// response back-pressure and mid-operation reset.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   seen   = 1'b0;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Monitor: compare each newly presented response against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rsp_valid) begin
      seen = 1'b0;
    end else if (!seen) begin
      seen = 1'b1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp rdata=%h err=%b", rsp_rdata, rsp_err);
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit push,
                       input logic [31:0] er, input logic ee);
    int n;
    if (clk) @(negedge clk);
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout got=0 exp=1");
      return;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    if (push) sb.push_back('{er, ee, ee ? 1 : 3, cyc});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd, input logic ee);
    issue(1'b1, f3, addr, wd, 1'b1, 32'h0, ee);
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] er, input logic ee);
    issue(1'b0, f3, addr, 32'h0, 1'b1, er, ee);
  endtask

  task automatic wait_idle();
    int n;
    if (clk) @(negedge clk);
    n = 0;
    while ((!req_ready || sb.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    rsp_ready  = 1'b1;

    #2;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    rst = 1'b1;

    // First request lands on the first edge after release (latency checked).
    st(3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
    ld(3'b010, 32'h10, 32'hDEADBEEF, 1'b0);

    st(3'b010, 32'h10, 32'h00000000, 1'b0);
    st(3'b000, 32'h13, 32'h00000080, 1'b0);
    ld(3'b000, 32'h13, 32'hFFFFFF80, 1'b0);
    ld(3'b100, 32'h13, 32'h00000080, 1'b0);
    ld(3'b010, 32'h10, 32'h80000000, 1'b0);

    ld(3'b001, 32'h21, 32'h0, 1'b1);
    st(3'b010, 32'h20, 32'hCAFEF00D, 1'b0);
    st(3'b010, 32'h22, 32'h11111111, 1'b1);
    ld(3'b010, 32'h20, 32'hCAFEF00D, 1'b0);

    ld(3'b010, 32'h400, 32'h0, 1'b1);
    ld(3'b011, 32'h0, 32'h0, 1'b1);
    st(3'b100, 32'h0, 32'h55, 1'b1);

    // Back-pressure: response must hold while rsp_ready is low.
    wait_idle();
    rsp_ready = 1'b0;
    ld(3'b010, 32'h10, 32'h80000000, 1'b0);
    @(negedge clk);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("hold_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("hold_rsp_rdata", rsp_rdata, 32'h80000000);
      chk("hold_req_ready", 32'(req_ready), 32'h0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("post_hs_req_ready", 32'(req_ready), 32'h1);
    chk("post_hs_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("post_hs_rsp_rdata", rsp_rdata, 32'h0);

    st(3'b001, 32'h12, 32'h0000ABCD, 1'b0);
    ld(3'b001, 32'h12, 32'hFFFFABCD, 1'b0);
    ld(3'b101, 32'h12, 32'h0000ABCD, 1'b0);
    ld(3'b010, 32'h10, 32'hABCD0000, 1'b0);

    // Reset during WAIT abandons the store and produces no response.
    st(3'b010, 32'h30, 32'h00000000, 1'b0);
    issue(1'b1, 3'b010, 32'h30, 32'h12345678, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(req_ready), 32'h1);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("aborted_rsp_valid", 32'(rsp_valid), 32'h0);
      @(negedge clk);
    end
    ld(3'b010, 32'h30, 32'h00000000, 1'b0);

    wait_idle();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d exp=0", sb.size());
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
